io_trap_responder: RTL and testbench

Responder side of the mapper's I/O virtualization path on the Nabu MegaMapper CPLD. When the guest Z80 initiates an I/O cycle to a trapped port window, this block stands in for the system device. It suppresses the system IORQ, captures the access, answers trapped reads from a supervisor-loaded byte, and pulses NMI. The supervisor then reads back the capture through mapper I/O ports 0x38–0x3B and acknowledges.

---
 rtl/mapper_pkg.sv | 26 ++
 rtl/nmi_pulse_gen.sv | 31 +++
 rtl/io_trap_responder.sv | 172 +++++++++++++++++
 tb/tb_io_trap_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared mapper constants: supervisor port map, status bit layout and trap FSM encoding.
package mapper_pkg;

    localparam logic [7:0] PORT_TRAP_ADDR = 8'h38;
    localparam logic [7:0] PORT_TRAP_DATA = 8'h39;
    localparam logic [7:0] PORT_STATUS    = 8'h3A;
    localparam logic [7:0] PORT_RESP      = 8'h3B;
    localparam logic [3:0] MAPPER_SPACE   = 4'h3;

    localparam int STAT_PENDING = 0;
    localparam int STAT_DIR     = 1;
    localparam int STAT_OVERRUN = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_NMI     = 2'd2;
    localparam logic [1:0] S_PENDING = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_CAPTURE = S_CAPTURE,
        ST_NMI     = S_NMI,
        ST_PENDING = S_PENDING
    } trap_state_e;

endpackage

// File: rtl/nmi_pulse_gen.sv
// Fixed-length NMI pulse: nmi_n_o is low for count_i clocks after a load strobe.
module nmi_pulse_gen (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [3:0] count_i,
    output logic       nmi_n_o,
    output logic       done_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nmi_n_o = (cnt_q == 4'd0);
    assign done_o  = (cnt_q == 4'd1);
endmodule

// File: rtl/io_trap_responder.sv
// Stands in for a system device on trapped guest I/O: suppresses IORQ, captures, pulses NMI.
// Optional feature macro TRAP_READ_EN: reads also trap and are answered from the resp register.
module io_trap_responder
    import mapper_pkg::*;
#(
    parameter logic [7:0] TRAP_BASE  = 8'h40,
    parameter logic [7:0] TRAP_MASK  = 8'hF0,
    parameter int         NMI_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire  [7:0] data,
    input  logic [7:0] addr,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic       trap_en,
    output logic       trap_sup_n,
    output logic       nmi_n,
    output logic [1:0] state_o,
    output logic       data_oe_o
);
    trap_state_e state_q, state_d;
    logic [7:0]  trap_addr_q, trap_addr_d;
    logic [7:0]  trap_data_q, trap_data_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic        ack_seen_q, ack_seen_d;
`ifdef TRAP_READ_EN
    logic        dir_q, dir_d;
    logic [7:0]  resp_q, resp_d;
`endif
    logic        io_cycle, in_window, candidate, hit, ack;
    logic        pulse_load, pulse_done;
    logic [7:0]  status, dout;
    logic        oe;

`ifdef TRAP_READ_EN
    assign io_cycle = !iorq_n && m1_n && (!rd_n || !wr_n);
`else
    assign io_cycle = !iorq_n && m1_n && !wr_n;
`endif
    assign in_window = ((addr & TRAP_MASK) == (TRAP_BASE & TRAP_MASK)) && (addr[7:4] != MAPPER_SPACE);
    assign candidate = io_cycle && in_window && trap_en;
    assign hit       = candidate && (state_q == ST_IDLE);
    assign ack       = !iorq_n && !wr_n && (addr == PORT_STATUS);

    // CAPTURE keeps the original cycle suppressed until its IORQ strobe ends.
    assign trap_sup_n = !(hit || state_q == ST_CAPTURE);

    always_comb begin
        state_d     = state_q;
        trap_addr_d = trap_addr_q;
        trap_data_d = trap_data_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        ack_seen_d  = ack_seen_q;
        pulse_load  = 1'b0;
`ifdef TRAP_READ_EN
        dir_d       = dir_q;
        resp_d      = resp_q;
        if (!iorq_n && !wr_n && addr == PORT_RESP) resp_d = data;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d     = ST_CAPTURE;
                    trap_addr_d = addr;
                    trap_data_d = wr_n ? 8'h00 : data;
`ifdef TRAP_READ_EN
                    dir_d       = !wr_n;
`endif
                end
            end
            ST_CAPTURE: begin
                if (iorq_n) begin
                    state_d    = ST_NMI;
                    pend_d     = 1'b1;
                    ack_seen_d = 1'b0;
                    pulse_load = 1'b1;
                end
            end
            ST_NMI: begin
                if (pulse_done) state_d = (ack_seen_q || ack) ? ST_IDLE : ST_PENDING;
            end
            ST_PENDING: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (candidate && (state_q == ST_NMI || state_q == ST_PENDING)) ovr_d = 1'b1;
        // Ack wins over a same-edge overrun; during NMI it is remembered so the pulse runs out.
        if (ack) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
            if (state_q == ST_NMI) ack_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            trap_addr_q <= 8'h00;
            trap_data_q <= 8'h00;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            ack_seen_q  <= 1'b0;
`ifdef TRAP_READ_EN
            dir_q       <= 1'b0;
            resp_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            trap_addr_q <= trap_addr_d;
            trap_data_q <= trap_data_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            ack_seen_q  <= ack_seen_d;
`ifdef TRAP_READ_EN
            dir_q       <= dir_d;
            resp_q      <= resp_d;
`endif
        end
    end

    always_comb begin
        status               = 8'h00;
        status[STAT_PENDING] = pend_q;
        status[STAT_OVERRUN] = ovr_q;
`ifdef TRAP_READ_EN
        status[STAT_DIR]     = dir_q;
`else
        status[STAT_DIR]     = 1'b1;
`endif
    end

    always_comb begin
        oe   = 1'b0;
        dout = 8'h00;
        if (!iorq_n && !rd_n) begin
            case (addr)
                PORT_TRAP_ADDR: begin oe = 1'b1; dout = trap_addr_q; end
                PORT_TRAP_DATA: begin oe = 1'b1; dout = trap_data_q; end
                PORT_STATUS:    begin oe = 1'b1; dout = status;      end
`ifdef TRAP_READ_EN
                PORT_RESP:      begin oe = 1'b1; dout = resp_q;      end
`endif
                default: ;
            endcase
`ifdef TRAP_READ_EN
            if (state_q == ST_CAPTURE && !dir_q) begin
                oe   = 1'b1;
                dout = resp_q;
            end
`endif
        end
    end

    assign data      = oe ? dout : 8'hzz;
    assign data_oe_o = oe;
    assign state_o   = state_q;

    nmi_pulse_gen u_pulse (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (pulse_load),
        .count_i (4'(NMI_CYCLES)),
        .nmi_n_o (nmi_n),
        .done_o  (pulse_done)
    );
endmodule

// File: tb/tb_io_trap_responder.sv
// Bench for io_trap_responder: bus-cycle driver tasks, expected-value queue, per-scenario tests.
module tb_io_trap_responder;
    import mapper_pkg::*;

    localparam int NMI_LEN = 4;
`ifdef TRAP_READ_EN
    localparam logic [7:0] RST_STATUS = 8'h00;
`else
    localparam logic [7:0] RST_STATUS = 8'h02;
`endif

    logic       clk = 1'b0;
    logic       reset_n, iorq_n, rd_n, wr_n, m1_n, trap_en, tb_drv;
    logic [7:0] addr, tb_dout;
    wire  [7:0] data;
    logic       trap_sup_n, nmi_n, data_oe_o;
    logic [1:0] state_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    assign data = tb_drv ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    io_trap_responder #(.TRAP_BASE(8'h40), .TRAP_MASK(8'hF0), .NMI_CYCLES(NMI_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data       (data),
        .addr       (addr),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .trap_en    (trap_en),
        .trap_sup_n (trap_sup_n),
        .nmi_n      (nmi_n),
        .state_o    (state_o),
        .data_oe_o  (data_oe_o)
    );

    task automatic bus_idle();
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; tb_drv = 1'b0;
    endtask

    // One IORQ cycle spanning two rising edges; sup0 is sampled before the capture edge, sup1 after.
    task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d, input logic is_wr, input logic m1,
                             output logic [7:0] v, output logic sup0, output logic sup1, output logic oe);
        @(negedge clk);
        addr = a; tb_dout = d; tb_drv = is_wr; m1_n = m1;
        iorq_n = 1'b0; rd_n = is_wr; wr_n = !is_wr;
        #1 sup0 = trap_sup_n;
        @(posedge clk);
        @(negedge clk);
        sup1 = trap_sup_n; v = data; oe = data_oe_o;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic sup_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] v; logic s0, s1, oe;
        bus_cycle(a, d, 1'b1, 1'b1, v, s0, s1, oe);
    endtask

    task automatic sup_read(input logic [7:0] a, output logic [7:0] v);
        logic s0, s1, oe;
        bus_cycle(a, 8'h00, 1'b0, 1'b1, v, s0, s1, oe);
    endtask

    task automatic wait_nmi(output int first, output int low);
        first = -1; low = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (!nmi_n) begin
                if (first < 0) first = i;
                low++;
            end else if (low > 0) begin
                break;
            end
        end
    endtask

    task automatic count_nmi_low(output int low);
        low = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!nmi_n) low++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v, e;
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi got %b exp 1", nmi_n); end
        checks++; if (trap_sup_n !== 1'b1) begin errors++; $display("FAIL reset_sup got %b exp 1", trap_sup_n); end
        checks++; if (data_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", data_oe_o); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_o, S_IDLE); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(RST_STATUS);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL reset_reg%0d got %h exp %h", i, v, e); end
        end
`ifdef TRAP_READ_EN
        exp_q.push_back(8'h00);
        sup_read(PORT_RESP, v); e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL reset_resp got %h exp %h", v, e); end
`endif
    endtask

    task automatic test_write_trap();
        logic [7:0] v, e; logic s0, s1, oe; int f, l;
        trap_en = 1'b1;
        bus_cycle(8'h42, 8'hA5, 1'b1, 1'b1, v, s0, s1, oe);
        checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL wr_sup_early got %b exp 0", s0); end
        checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL wr_sup_capture got %b exp 0", s1); end
        wait_nmi(f, l);
        checks++; if (f !== 0) begin errors++; $display("FAIL wr_nmi_start got %0d exp 0", f); end
        checks++; if (l !== NMI_LEN) begin errors++; $display("FAIL wr_nmi_len got %0d exp %0d", l, NMI_LEN); end
        checks++; if (state_o !== S_PENDING) begin errors++; $display("FAIL wr_state got %0d exp %0d", state_o, S_PENDING); end
        exp_q.push_back(8'h42); exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL wr_reg%0d got %h exp %h", i, v, e); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] v, e; logic s0, s1, oe; int l;
`ifndef TRAP_READ_EN
        bus_cycle(8'h47, 8'h00, 1'b0, 1'b1, v, s0, s1, oe);
        checks++; if ({s0, s1, oe} !== 3'b110) begin errors++; $display("FAIL rd_untrapped got sup %b%b oe %b exp 11 0", s0, s1, oe); end
        exp_q.push_back(8'h03);
        sup_read(PORT_STATUS, v); e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL rd_no_overrun got %h exp %h", v, e); end
`endif
        bus_cycle(8'h41, 8'h11, 1'b1, 1'b1, v, s0, s1, oe);
        checks++; if ({s0, s1} !== 2'b11) begin errors++; $display("FAIL ovr_sup got %b%b exp 11", s0, s1); end
        count_nmi_low(l);
        checks++; if (l !== 0) begin errors++; $display("FAIL ovr_nmi got %0d low cycles exp 0", l); end
        exp_q.push_back(8'h42); exp_q.push_back(8'hA5); exp_q.push_back(8'h07);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL ovr_reg%0d got %h exp %h", i, v, e); end
        end
    endtask

    task automatic test_ack();
        logic [7:0] v, e;
        sup_write(PORT_STATUS, 8'hFF);
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL ack_state got %0d exp %0d", state_o, S_IDLE); end
        exp_q.push_back(8'h02);
        sup_read(PORT_STATUS, v); e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL ack_status got %h exp %h", v, e); end
    endtask

    task automatic test_read_trap();
        logic [7:0] v, e; logic s0, s1, oe; int f, l;
`ifdef TRAP_READ_EN
        sup_write(PORT_RESP, 8'h5C);
        exp_q.push_back(8'h5C);
        sup_read(PORT_RESP, v); e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL resp_readback got %h exp %h", v, e); end
        exp_q.push_back(8'h5C);
        bus_cycle(8'h47, 8'h00, 1'b0, 1'b1, v, s0, s1, oe);
        e = exp_q.pop_front();
        checks++; if ({s0, s1, oe} !== 3'b001) begin errors++; $display("FAIL rd_trap_ctl got sup %b%b oe %b exp 00 1", s0, s1, oe); end
        checks++; if (v !== e) begin errors++; $display("FAIL rd_trap_data got %h exp %h", v, e); end
        wait_nmi(f, l);
        checks++; if (l !== NMI_LEN) begin errors++; $display("FAIL rd_nmi_len got %0d exp %0d", l, NMI_LEN); end
        exp_q.push_back(8'h47); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL rd_reg%0d got %h exp %h", i, v, e); end
        end
        sup_write(PORT_STATUS, 8'h00);
        exp_q.push_back(8'h00);
        sup_read(PORT_STATUS, v); e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL rd_ack_status got %h exp %h", v, e); end
`else
        bus_cycle(PORT_RESP, 8'h00, 1'b0, 1'b1, v, s0, s1, oe);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL resp_port_oe got %b exp 0", oe); end
`endif
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL rd_end_state got %0d exp %0d", state_o, S_IDLE); end
    endtask

    task automatic test_non_hits();
        logic [7:0] v; logic s0, s1, oe; int l;
        // {addr, is_write, m1_n, trap_en}
        logic [10:0] cases [4];
        cases[0] = {8'h80, 1'b1, 1'b1, 1'b1};
        cases[1] = {8'h40, 1'b0, 1'b0, 1'b1};
        cases[2] = {8'h40, 1'b1, 1'b0, 1'b1};
        cases[3] = {8'h40, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            trap_en = cases[i][0];
            bus_cycle(cases[i][10:3], 8'h5A, cases[i][2], cases[i][1], v, s0, s1, oe);
            checks++; if ({s0, s1, oe} !== 3'b110) begin errors++; $display("FAIL nohit%0d_ctl got sup %b%b oe %b exp 11 0", i, s0, s1, oe); end
            count_nmi_low(l);
            checks++; if (l !== 0 || state_o !== S_IDLE) begin errors++; $display("FAIL nohit%0d_nmi got %0d low state %0d exp 0 low state 0", i, l, state_o); end
        end
        trap_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, e, a, d; logic s0, s1, oe; int f, l;
        for (int k = 0; k < 3; k++) begin
            a = 8'h40 | 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            bus_cycle(a, d, 1'b1, 1'b1, v, s0, s1, oe);
            checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL b2b%0d_sup got %b%b exp 00", k, s0, s1); end
            wait_nmi(f, l);
            checks++; if (f !== 0 || l !== NMI_LEN) begin errors++; $display("FAIL b2b%0d_nmi got start %0d len %0d exp 0 %0d", k, f, l, NMI_LEN); end
            exp_q.push_back(a); exp_q.push_back(d); exp_q.push_back(8'h03);
            for (int i = 0; i < 3; i++) begin
                sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
                checks++; if (v !== e) begin errors++; $display("FAIL b2b%0d_reg%0d got %h exp %h", k, i, v, e); end
            end
            sup_write(PORT_STATUS, 8'h00);
            checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL b2b%0d_state got %0d exp 0", k, state_o); end
        end
    endtask

    task automatic test_ack_during_nmi();
        logic [7:0] v, e; logic s0, s1, oe; int f, l;
        bus_cycle(8'h4F, 8'h3C, 1'b1, 1'b1, v, s0, s1, oe);
        sup_write(PORT_STATUS, 8'h00);
        wait_nmi(f, l);
        checks++; if (f !== 0 || l !== 1) begin errors++; $display("FAIL acknmi_tail got start %0d len %0d exp 0 1", f, l); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL acknmi_state got %0d exp 0", state_o); end
        exp_q.push_back(8'h4F); exp_q.push_back(8'h3C); exp_q.push_back(8'h02);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL acknmi_reg%0d got %h exp %h", i, v, e); end
        end
    endtask

    task automatic test_reset_mid_nmi();
        logic [7:0] v, e; logic s0, s1, oe;
        bus_cycle(8'h44, 8'h99, 1'b1, 1'b1, v, s0, s1, oe);
        @(negedge clk);
        @(negedge clk);
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL midnmi_pre got %b exp 0", nmi_n); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL midnmi_nmi got %b exp 1", nmi_n); end
        checks++; if ({trap_sup_n, data_oe_o} !== 2'b10) begin errors++; $display("FAIL midnmi_bus got %b%b exp 10", trap_sup_n, data_oe_o); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL midnmi_state got %0d exp 0", state_o); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(RST_STATUS);
        for (int i = 0; i < 3; i++) begin
            sup_read(8'(PORT_TRAP_ADDR + i), v); e = exp_q.pop_front();
            checks++; if (v !== e) begin errors++; $display("FAIL midnmi_reg%0d got %h exp %h", i, v, e); end
        end
    endtask

    initial begin
        reset_n = 1'b0; trap_en = 1'b0; addr = 8'h00; tb_dout = 8'h00;
        bus_idle();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_write_trap();
        test_overrun();
        test_ack();
        test_read_trap();
        test_non_hits();
        test_back_to_back();
        test_ack_during_nmi();
        test_reset_mid_nmi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
